// File: rtl/cnn_frame_seq.sv
// cnn_frame_seq: multi-channel raster timing generator for the CNN front end.
// Emits vsync/hsync/data phases plus row/col/channel coordinates per job.
// Optional build macro: CNN_FRAME_SEQ_PAD_EN adds a one-pixel padding ring
// (q_pad input, o_pad output).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for q_start with non-zero width/height
// S_VSYNC | frame start-up phase, start_up_delay+1 cycles
// S_HSYNC | line start phase, hsync_delay+1 cycles
// S_DATA  | pixel phase, one pixel per non-stalled cycle
module cnn_frame_seq #(
    parameter int W_SIZE       = 12,
    parameter int W_DELAY      = 12,
    parameter int W_CH         = 4,
    parameter int W_FRAME_SIZE = 2*W_SIZE+1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic [W_DELAY-1:0]      q_start_up_delay,
    input  logic [W_DELAY-1:0]      q_hsync_delay,
    input  logic [W_CH-1:0]         q_num_ch,
    input  logic                    q_start,
`ifdef CNN_FRAME_SEQ_PAD_EN
    input  logic                    q_pad,
    output logic                    o_pad,
`endif
    input  logic                    i_stall,
    output logic                    o_ctrl_vsync_run,
    output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
    output logic                    o_ctrl_hsync_run,
    output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
    output logic                    o_ctrl_data_run,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic [W_CH-1:0]         o_ch,
    output logic [W_FRAME_SIZE-1:0] o_data_count,
    output logic                    o_end_line,
    output logic                    o_end_frame,
    output logic                    o_end_all,
    output logic                    o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_HSYNC, S_DATA} state_t;

    state_t                    state, state_nxt;
    logic [W_SIZE-1:0]         sh_width, sh_height;
    logic [W_DELAY-1:0]        sh_su, sh_hs;
    logic [W_CH-1:0]           sh_nch;
    logic [W_DELAY-1:0]        vcnt, hcnt;
    logic [W_SIZE-1:0]         row, col;
    logic [W_CH-1:0]           ch;
    logic [W_FRAME_SIZE-1:0]   dcount;

    logic                      start_ok;
    logic [W_SIZE-1:0]         eff_w, eff_h;
    logic [W_FRAME_SIZE-1:0]   frame_last;
    logic                      vsync_done, hsync_done;
    logic                      data_run, end_line, end_frame, end_all;

    assign start_ok = q_start && (q_width != '0) && (q_height != '0);

`ifdef CNN_FRAME_SEQ_PAD_EN
    logic sh_pad;
    // Padded geometry adds one ring of positions around the image.
    assign eff_w = sh_pad ? sh_width  + W_SIZE'(2) : sh_width;
    assign eff_h = sh_pad ? sh_height + W_SIZE'(2) : sh_height;
    assign o_pad = sh_pad && data_run &&
                   ((row == '0) || (row == sh_height + W_SIZE'(1)) ||
                    (col == '0) || (col == sh_width  + W_SIZE'(1)));
`else
    assign eff_w = sh_width;
    assign eff_h = sh_height;
`endif

    assign frame_last = W_FRAME_SIZE'(eff_w) * W_FRAME_SIZE'(eff_h) - W_FRAME_SIZE'(1);
    assign vsync_done = (vcnt == sh_su);
    assign hsync_done = (hcnt == sh_hs);
    assign data_run   = (state == S_DATA) && !i_stall;
    assign end_line   = data_run && (col == eff_w - W_SIZE'(1));
    assign end_frame  = data_run && (dcount == frame_last);
    assign end_all    = end_frame && (ch == sh_nch - W_CH'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; DATA only leaves on the non-stalled last pixel of a line.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok)   state_nxt = S_VSYNC;
            S_VSYNC: if (vsync_done) state_nxt = S_HSYNC;
            S_HSYNC: if (hsync_done) state_nxt = S_DATA;
            S_DATA: begin
                if (end_line) begin
                    if (end_all)        state_nxt = S_IDLE;
                    else if (end_frame) state_nxt = S_VSYNC;
                    else                state_nxt = S_HSYNC;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Configuration shadows, captured only when a job is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_width  <= '0;
            sh_height <= '0;
            sh_su     <= '0;
            sh_hs     <= '0;
            sh_nch    <= '0;
`ifdef CNN_FRAME_SEQ_PAD_EN
            sh_pad    <= 1'b0;
`endif
        end else if ((state == S_IDLE) && start_ok) begin
            sh_width  <= q_width;
            sh_height <= q_height;
            sh_su     <= q_start_up_delay;
            sh_hs     <= q_hsync_delay;
            sh_nch    <= (q_num_ch == '0) ? W_CH'(1) : q_num_ch;
`ifdef CNN_FRAME_SEQ_PAD_EN
            sh_pad    <= q_pad;
`endif
        end
    end

    // Phase counters run only while their phase is active and restart at the exit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt <= '0;
            hcnt <= '0;
        end else begin
            vcnt <= ((state == S_VSYNC) && !vsync_done) ? vcnt + W_DELAY'(1) : '0;
            hcnt <= ((state == S_HSYNC) && !hsync_done) ? hcnt + W_DELAY'(1) : '0;
        end
    end

    // Pixel coordinates and channel index; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE)) begin
            row    <= '0;
            col    <= '0;
            dcount <= '0;
            ch     <= '0;
        end else if (data_run) begin
            if (end_frame) begin
                row    <= '0;
                col    <= '0;
                dcount <= '0;
                ch     <= end_all ? '0 : ch + W_CH'(1);
            end else if (end_line) begin
                col    <= '0;
                row    <= row + W_SIZE'(1);
                dcount <= dcount + W_FRAME_SIZE'(1);
            end else begin
                col    <= col + W_SIZE'(1);
                dcount <= dcount + W_FRAME_SIZE'(1);
            end
        end
    end

    assign o_ctrl_vsync_run = (state == S_VSYNC);
    assign o_ctrl_vsync_cnt = vcnt;
    assign o_ctrl_hsync_run = (state == S_HSYNC);
    assign o_ctrl_hsync_cnt = hcnt;
    assign o_ctrl_data_run  = data_run;
    assign o_row            = row;
    assign o_col            = col;
    assign o_ch             = ch;
    assign o_data_count     = dcount;
    assign o_end_line       = end_line;
    assign o_end_frame      = end_frame;
    assign o_end_all        = end_all;
    assign o_busy           = (state != S_IDLE);

endmodule

// File: tb/tb_cnn_frame_seq.sv
// Bench for cnn_frame_seq: a nested-loop raster model (channels > frames >
// lines > pixels) drives the DUT cycle by cycle and predicts every output.
module tb_cnn_frame_seq;

    localparam int W_SIZE       = 12;
    localparam int W_DELAY      = 12;
    localparam int W_CH         = 4;
    localparam int W_FRAME_SIZE = 2*W_SIZE+1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [W_SIZE-1:0]       q_width, q_height;
    logic [W_DELAY-1:0]      q_start_up_delay, q_hsync_delay;
    logic [W_CH-1:0]         q_num_ch;
    logic                    q_start, i_stall;
    logic                    o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run;
    logic [W_DELAY-1:0]      o_ctrl_vsync_cnt, o_ctrl_hsync_cnt;
    logic [W_SIZE-1:0]       o_row, o_col;
    logic [W_CH-1:0]         o_ch;
    logic [W_FRAME_SIZE-1:0] o_data_count;
    logic                    o_end_line, o_end_frame, o_end_all, o_busy;
`ifdef CNN_FRAME_SEQ_PAD_EN
    logic                    q_pad, o_pad;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    cnn_frame_seq #(.W_SIZE(W_SIZE), .W_DELAY(W_DELAY), .W_CH(W_CH),
                    .W_FRAME_SIZE(W_FRAME_SIZE)) dut (
        .clk(clk), .rst(rst),
        .q_width(q_width), .q_height(q_height),
        .q_start_up_delay(q_start_up_delay), .q_hsync_delay(q_hsync_delay),
        .q_num_ch(q_num_ch), .q_start(q_start),
`ifdef CNN_FRAME_SEQ_PAD_EN
        .q_pad(q_pad), .o_pad(o_pad),
`endif
        .i_stall(i_stall),
        .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt),
        .o_ctrl_hsync_run(o_ctrl_hsync_run), .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt),
        .o_ctrl_data_run(o_ctrl_data_run), .o_row(o_row), .o_col(o_col),
        .o_ch(o_ch), .o_data_count(o_data_count), .o_end_line(o_end_line),
        .o_end_frame(o_end_frame), .o_end_all(o_end_all), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled away from the edge.
    task automatic step(input bit scramble);
        @(posedge clk);
        #2;
        q_start = 1'b0;
        if (scramble) begin
            q_width          = W_SIZE'($urandom);
            q_height         = W_SIZE'($urandom);
            q_start_up_delay = W_DELAY'($urandom);
            q_hsync_delay    = W_DELAY'($urandom);
            q_num_ch         = W_CH'($urandom);
`ifdef CNN_FRAME_SEQ_PAD_EN
            q_pad            = 1'($urandom);
`endif
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(o_busy), 0);
        chk({tag, "_vrun"},  32'(o_ctrl_vsync_run), 0);
        chk({tag, "_hrun"},  32'(o_ctrl_hsync_run), 0);
        chk({tag, "_drun"},  32'(o_ctrl_data_run), 0);
        chk({tag, "_vcnt"},  32'(o_ctrl_vsync_cnt), 0);
        chk({tag, "_hcnt"},  32'(o_ctrl_hsync_cnt), 0);
        chk({tag, "_row"},   32'(o_row), 0);
        chk({tag, "_col"},   32'(o_col), 0);
        chk({tag, "_ch"},    32'(o_ch), 0);
        chk({tag, "_dcnt"},  32'(o_data_count), 0);
        chk({tag, "_ends"},  32'({o_end_line, o_end_frame, o_end_all}), 0);
    endtask

    // Reference model: a job is nch frames; each frame is a VSYNC of su+1 cycles,
    // then per line an HSYNC of hs+1 cycles followed by w pixels (stalls stretch pixels).
    task automatic run_job(input int w, input int h, input int su, input int hs,
                           input int nch, input bit pad, input bit stl,
                           output int n_end_all);
        int nc, we, he, idx, tot;
        bit st;
        nc = (nch == 0) ? 1 : nch;
        we = pad ? w + 2 : w;
        he = pad ? h + 2 : h;
        tot = we * he;
        n_end_all = 0;
        q_width = W_SIZE'(w); q_height = W_SIZE'(h);
        q_start_up_delay = W_DELAY'(su); q_hsync_delay = W_DELAY'(hs);
        q_num_ch = W_CH'(nch);
`ifdef CNN_FRAME_SEQ_PAD_EN
        q_pad = pad;
`endif
        q_start = 1'b1;
        i_stall = 1'b0;
        step(1);
        for (int c = 0; c < nc; c++) begin
            for (int i = 0; i <= su; i++) begin
                i_stall = stl ? 1'($urandom) : 1'b0;
                #1;
                chk("v_run",  32'(o_ctrl_vsync_run), 1);
                chk("v_cnt",  32'(o_ctrl_vsync_cnt), 32'(i));
                chk("v_hrun", 32'(o_ctrl_hsync_run), 0);
                chk("v_drun", 32'(o_ctrl_data_run), 0);
                chk("v_ch",   32'(o_ch), 32'(c));
                chk("v_busy", 32'(o_busy), 1);
                step(1);
            end
            idx = 0;
            for (int r = 0; r < he; r++) begin
                for (int i = 0; i <= hs; i++) begin
                    i_stall = stl ? 1'($urandom) : 1'b0;
                    #1;
                    chk("h_run",  32'(o_ctrl_hsync_run), 1);
                    chk("h_cnt",  32'(o_ctrl_hsync_cnt), 32'(i));
                    chk("h_vrun", 32'(o_ctrl_vsync_run), 0);
                    chk("h_drun", 32'(o_ctrl_data_run), 0);
                    step(1);
                end
                for (int x = 0; x < we; x++) begin
                    do begin
                        st = stl ? ($urandom_range(0, 3) == 0) : 1'b0;
                        i_stall = st;
                        #1;
                        chk("d_drun", 32'(o_ctrl_data_run), 32'(!st));
                        chk("d_vh",   32'({o_ctrl_vsync_run, o_ctrl_hsync_run}), 0);
                        chk("d_row",  32'(o_row), 32'(r));
                        chk("d_col",  32'(o_col), 32'(x));
                        chk("d_cnt",  32'(o_data_count), 32'(idx));
                        chk("d_ch",   32'(o_ch), 32'(c));
                        chk("d_eol",  32'(o_end_line), 32'(!st && x == we - 1));
                        chk("d_eof",  32'(o_end_frame), 32'(!st && idx == tot - 1));
                        chk("d_eoa",  32'(o_end_all),
                            32'(!st && idx == tot - 1 && c == nc - 1));
`ifdef CNN_FRAME_SEQ_PAD_EN
                        chk("d_pad",  32'(o_pad),
                            32'(!st && pad && (r == 0 || r == he - 1 || x == 0 || x == we - 1)));
`endif
                        if (!st && idx == tot - 1 && c == nc - 1) n_end_all++;
                        step(1);
                    end while (st);
                    idx++;
                end
            end
        end
        i_stall = 1'b0;
        #1;
        chk("job_done_busy", 32'(o_busy), 0);
        chk("job_done_ch",   32'(o_ch), 0);
    endtask

    initial begin
        int ea, guard;
        bit pad;
        rst = 1'b1; q_start = 1'b0; i_stall = 1'b0;
        q_width = '0; q_height = '0; q_start_up_delay = '0; q_hsync_delay = '0; q_num_ch = '0;
`ifdef CNN_FRAME_SEQ_PAD_EN
        q_pad = 1'b0;
`endif
        step(0); step(0);
        chk_idle("reset");
        rst = 1'b0;
        step(0);

        // Basic 4x2 single-channel job.
        run_job(4, 2, 2, 1, 1, 1'b0, 1'b0, ea);
        chk("t1_end_all_once", 32'(ea), 1);
        // Three channels of 3x2.
        run_job(3, 2, 1, 0, 3, 1'b0, 1'b0, ea);
        chk("t2_end_all_once", 32'(ea), 1);
        // Single-pixel frames, width 1, num_ch 0 treated as 1, stalls.
        run_job(1, 1, 0, 0, 2, 1'b0, 1'b1, ea);
        run_job(1, 3, 0, 2, 0, 1'b0, 1'b1, ea);
        run_job(4, 1, 0, 0, 1, 1'b0, 1'b1, ea);
`ifdef CNN_FRAME_SEQ_PAD_EN
        run_job(2, 2, 1, 1, 1, 1'b1, 1'b0, ea);
`endif

        // Randomised jobs.
        for (int j = 0; j < 25; j++) begin
`ifdef CNN_FRAME_SEQ_PAD_EN
            pad = 1'($urandom);
`else
            pad = 1'b0;
`endif
            run_job($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), pad, 1'($urandom), ea);
            chk("rand_end_all_once", 32'(ea), 1);
        end

        // Zero dimensions are ignored at start.
        q_width = '0; q_height = W_SIZE'(3); q_num_ch = W_CH'(1); q_start = 1'b1;
        step(0);
        chk("zero_w_busy", 32'(o_busy), 0);
        q_width = W_SIZE'(3); q_height = '0; q_start = 1'b1;
        step(0);
        chk("zero_h_busy", 32'(o_busy), 0);

        // Reset mid-job while in DATA on row 1.
        q_width = W_SIZE'(3); q_height = W_SIZE'(2); q_start_up_delay = '0;
        q_hsync_delay = '0; q_num_ch = W_CH'(1); q_start = 1'b1;
        step(0);
        guard = 0;
        while (!(o_ctrl_data_run && o_row == W_SIZE'(1)) && guard < 50) begin
            step(0);
            guard++;
        end
        chk("rst_reach_row1", 32'(guard < 50), 1);
        rst = 1'b1;
        step(0);
        chk_idle("midrst");
        rst = 1'b0;
        step(0);
        run_job(2, 2, 0, 0, 1, 1'b0, 1'b0, ea);
        chk("post_rst_end_all", 32'(ea), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
